// File: rtl/mine_field_gen_pkg.sv
// ============================================================================
// Module      : mine_field_gen_pkg
// Description : Shared game constants and the 7-bit LFSR next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mine_field_gen_pkg;

  localparam logic [1:0] c_EASY   = 2'd0;
  localparam logic [1:0] c_MEDIUM = 2'd1;
  localparam logic [1:0] c_HARD   = 2'd2;

  localparam logic [5:0] c_MASK_EASY   = 6'h0F;
  localparam logic [5:0] c_MASK_MEDIUM = 6'h1F;
  localparam logic [5:0] c_MASK_HARD   = 6'h3F;

  localparam int c_MINES_EASY   = 3;
  localparam int c_MINES_MEDIUM = 6;
  localparam int c_MINES_HARD   = 12;

  localparam logic [6:0] c_LFSR_RESET = 7'h40;

  // x^7 + x^6 + 1, maximal length (period 127)
  function automatic logic [6:0] lfsr7_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mine_lfsr7.sv
// ============================================================================
// Module      : mine_lfsr7
// Description : 7-bit Fibonacci LFSR with parallel load and advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mine_lfsr7
  import mine_field_gen_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       advance,
  output logic [6:0] lfsr
);

  logic [6:0] r_lfsr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lfsr <= c_LFSR_RESET;
    end else if (load) begin
      r_lfsr <= load_value;
    end else if (advance) begin
      r_lfsr <= lfsr7_next(r_lfsr);
    end
  end

  assign lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/mine_field_gen.sv
// ============================================================================
// Module      : mine_field_gen
// Description : Seeds an LFSR from a difficulty counter and places distinct
//               mines on the selected board, avoiding the first-click cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mine_field_gen
  import mine_field_gen_pkg::*;
#(
  parameter int MINES_EASY   = c_MINES_EASY,
  parameter int MINES_MEDIUM = c_MINES_MEDIUM,
  parameter int MINES_HARD   = c_MINES_HARD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  difficulty,
  input  logic [3:0]  seed_easy,
  input  logic [4:0]  seed_medium,
  input  logic [5:0]  seed_hard,
  input  logic [5:0]  safe_cell,
  output logic        busy,
  output logic        done,
  output logic [63:0] mine_map,
  output logic [3:0]  mine_count
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_GEN  = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [63:0] r_map;
  logic [3:0]  r_count;
  logic        r_done;
  logic [5:0]  r_safe;
  logic [5:0]  r_mask;
  logic [3:0]  r_target;

  logic        w_load;
  logic        w_advance;
  logic        w_busy;
  logic [6:0]  w_seed;
  logic [5:0]  w_mask_sel;
  logic [3:0]  w_target_sel;
  logic [6:0]  w_lfsr;
  logic [5:0]  w_cand;
  logic        w_accept;
  logic        w_last;

  always_comb begin
    w_seed       = {1'b1, seed_hard};
    w_mask_sel   = c_MASK_HARD;
    w_target_sel = 4'(MINES_HARD);
    case (difficulty)
      c_EASY: begin
        w_seed       = {3'b100, seed_easy};
        w_mask_sel   = c_MASK_EASY;
        w_target_sel = 4'(MINES_EASY);
      end
      c_MEDIUM: begin
        w_seed       = {2'b10, seed_medium};
        w_mask_sel   = c_MASK_MEDIUM;
        w_target_sel = 4'(MINES_MEDIUM);
      end
      default: ;
    endcase
  end

  mine_lfsr7 u_lfsr (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (w_load),
    .load_value (w_seed),
    .advance    (w_advance),
    .lfsr       (w_lfsr)
  );

  // Masking the candidate keeps every bit above the board size at zero.
  assign w_cand   = w_lfsr[5:0] & r_mask;
  assign w_accept = (r_state == c_GEN) && (w_cand != r_safe) && !r_map[w_cand];
  assign w_last   = w_accept && ((r_count + 4'd1) == r_target);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_next = c_GEN;
      c_GEN:   if (w_last) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == c_GEN);
    w_load    = (r_state == c_IDLE) && start;
    w_advance = (r_state == c_GEN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_map    <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_safe   <= '0;
      r_mask   <= '0;
      r_target <= '0;
    end else if (w_load) begin
      r_map    <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_safe   <= safe_cell;
      r_mask   <= w_mask_sel;
      r_target <= w_target_sel;
    end else if (w_accept) begin
      r_map[w_cand] <= 1'b1;
      r_count       <= r_count + 4'd1;
      if (w_last) r_done <= 1'b1;
    end
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign mine_map   = r_map;
  assign mine_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mine_field_gen.sv
// ============================================================================
// Module      : tb_mine_field_gen
// Description : Directed self-checking bench for mine_field_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mine_field_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [1:0]  difficulty;
  logic [3:0]  seed_easy;
  logic [4:0]  seed_medium;
  logic [5:0]  seed_hard;
  logic [5:0]  safe_cell;
  logic        busy;
  logic        done;
  logic [63:0] mine_map;
  logic [3:0]  mine_count;

  int n_checks = 0;
  int n_pass   = 0;

  mine_field_gen dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .difficulty (difficulty),
    .seed_easy  (seed_easy),
    .seed_medium(seed_medium),
    .seed_hard  (seed_hard),
    .safe_cell  (safe_cell),
    .busy       (busy),
    .done       (done),
    .mine_map   (mine_map),
    .mine_count (mine_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_gen(input logic [1:0] d, input logic [5:0] sd, input logic [5:0] sf);
    difficulty  = d;
    seed_easy   = sd[3:0];
    seed_medium = sd[4:0];
    seed_hard   = sd;
    safe_cell   = sf;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  // Reference placement: walk the maximal-length sequence x^7+x^6+1
  function automatic void model(input logic [1:0] d, input logic [5:0] sd, input logic [5:0] sf,
                                output logic [63:0] m, output int k);
    int         tgt;
    int         n;
    logic [5:0] msk;
    logic [6:0] r;
    logic [5:0] idx;
    case (d)
      2'd0:    begin tgt = 3;  msk = 6'h0F; r = {3'b100, sd[3:0]}; end
      2'd1:    begin tgt = 6;  msk = 6'h1F; r = {2'b10, sd[4:0]};  end
      default: begin tgt = 12; msk = 6'h3F; r = {1'b1, sd};        end
    endcase
    m = '0;
    n = 0;
    k = 0;
    while (n < tgt && k < 500) begin
      k++;
      idx = r[5:0] & msk;
      if (idx != sf && !m[idx]) begin
        m[idx] = 1'b1;
        n++;
      end
      r = {r[5:0], r[6] ^ r[5]};
    end
  endfunction

  task automatic run_and_check(input string tag, input logic [1:0] d, input logic [5:0] sd,
                               input logic [5:0] sf);
    logic [63:0] m;
    int          k;
    int          cyc;
    model(d, sd, sf, m, k);
    start_gen(d, sd, sf);
    wait_done(cyc);
    check({tag, "_map"}, mine_map, m);
    check({tag, "_count"}, 64'(mine_count), 64'($countones(m)));
    check({tag, "_cycles"}, 64'(cyc), 64'(k));
    check({tag, "_safe"}, 64'(mine_map[sf]), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int          cyc;
    logic [63:0] m;
    int          k;
    logic [5:0]  sd;
    logic [5:0]  sf;

    Reset = 1'b1; start = 1'b0; difficulty = 2'd0;
    seed_easy = '0; seed_medium = '0; seed_hard = '0; safe_cell = '0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_map", mine_map, 64'h0);
    check("rst_count", 64'(mine_count), 64'(0));

    // Easy, seed 0: candidates 0,1,2 all accepted
    start_gen(2'd0, 6'd0, 6'd5);
    check("e0_busy_rise", 64'(busy), 64'(1));
    check("e0_done_low", 64'(done), 64'(0));
    wait_done(cyc);
    check("e0_cycles", 64'(cyc), 64'(3));
    check("e0_map", mine_map, 64'h7);
    check("e0_count", 64'(mine_count), 64'(3));
    check("e0_busy_fall", 64'(busy), 64'(0));

    // Easy, seed 0, safe 1: sequence 0,1(rej),2,4
    start_gen(2'd0, 6'd0, 6'd1);
    check("e1_done_drop", 64'(done), 64'(0));
    wait_done(cyc);
    check("e1_cycles", 64'(cyc), 64'(4));
    check("e1_map", mine_map, 64'h15);
    check("e1_count", 64'(mine_count), 64'(3));

    for (int i = 0; i < 32; i++) begin
      sd = 6'($urandom_range(0, 63));
      sf = 6'($urandom_range(0, 63));
      run_and_check("med", 2'd1, sd, sf);
      check("med_n", 64'(mine_count), 64'(6));
      check("med_hi", mine_map[63:32], 64'(0));
      sd = 6'($urandom_range(0, 63));
      sf = 6'($urandom_range(0, 63));
      run_and_check("hard", 2'd2, sd, sf);
      check("hard_n", 64'(mine_count), 64'(12));
    end

    run_and_check("d3", 2'd3, 6'd17, 6'd40);
    check("d3_n", 64'(mine_count), 64'(12));

    // Start and input changes while busy must be ignored
    model(2'd2, 6'd9, 6'd3, m, k);
    start_gen(2'd2, 6'd9, 6'd3);
    tick();
    difficulty = 2'd0; seed_easy = 4'hA; seed_medium = 5'h15; seed_hard = 6'h2A;
    safe_cell = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("busy_ign_map", mine_map, m);
    check("busy_ign_cycles", 64'(cyc), 64'(k));
    check("busy_ign_count", 64'(mine_count), 64'(12));

    // Start while done: new request
    start_gen(2'd0, 6'd0, 6'd5);
    check("redo_done_drop", 64'(done), 64'(0));
    check("redo_busy", 64'(busy), 64'(1));
    wait_done(cyc);
    check("redo_map", mine_map, 64'h7);

    // Reset mid-generation with start on the same edge
    start_gen(2'd2, 6'd1, 6'd0);
    tick();
    Reset = 1'b1; start = 1'b1;
    tick();
    Reset = 1'b0; start = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_map", mine_map, 64'h0);
    check("abort_count", 64'(mine_count), 64'(0));
    tick();
    check("abort_idle", 64'(busy), 64'(0));
    check("abort_map2", mine_map, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mine_field_gen.md
# mine_field_gen

Consumes the free-running difficulty counters and turns one sampled value into a complete mine placement for the selected board. On a start pulse it seeds a 7-bit LFSR from the matching counter and places a fixed number of distinct mines, never on the protected first-click cell. The result is a 64-bit mine map for the game-board logic. `busy` is meant to drive the counter block's `enable`, so the counters freeze while a board is being generated.

## Interface
Parameters:
- `MINES_EASY`, default 3: mines on the 4x4 board (16 cells, indices 0-15).
- `MINES_MEDIUM`, default 6: mines on the 32-cell board (indices 0-31).
- `MINES_HARD`, default 12: mines on the 8x8 board (64 cells, indices 0-63).

Ports:
- `Clk`  in  1  single clock; all logic on posedge.
- `Reset`  in  1  synchronous, active-high.
- `start`  in  1  request a new board; sampled only in IDLE.
- `difficulty`  in  2  0 = easy, 1 = medium, 2 and 3 = hard.
- `seed_easy`  in  4  easy counter value.
- `seed_medium`  in  5  medium counter value.
- `seed_hard`  in  6  hard counter value.
- `safe_cell`  in  6  cell that must never be mined; latched at start.
- `busy`  out  1  high while generating.
- `done`  out  1  board valid; held until the next accepted start.
- `mine_map`  out  64  bit i = 1 means cell i holds a mine.
- `mine_count`  out  4  mines placed so far.

## Operation
- States: IDLE and GEN.
- IDLE, start = 1:
  - Latch difficulty, safe_cell, target count and cell mask (0x0F, 0x1F or 0x3F).
  - Load the LFSR with {1'b1, seed zero-extended to 6 bits}, e.g. easy gives {1, 00, seed_easy}. The LFSR is therefore never zero.
  - Clear mine_map and mine_count, clear done, go to GEN.
- GEN, each cycle:
  - cand = lfsr[5:0] & mask.
  - Accept cand when cand != safe_cell and mine_map[cand] = 0: set that bit and increment mine_count.
  - Advance the LFSR every cycle, accepted or not: next = {lfsr[5:0], lfsr[6]^lfsr[5]} (period 127).
  - When an accept brings mine_count to target: set done, go to IDLE.
- Bits of mine_map at or above the board size are always 0.
- Termination: one LFSR period covers every value of lfsr[5:0], so generation always finishes in at most 127 GEN cycles.
- A safe_cell outside the board is legal; it simply never matches a candidate.
- Latched inputs are fixed for the whole generation, so input changes during GEN have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, mine_map 0, mine_count 0, LFSR 7'h40.
- start accepted at edge N: busy = 1 from cycle N+1. The first candidate is evaluated at edge N+1.
- With k GEN cycles (accepts plus rejects): after edge N+k, busy = 0, done = 1, and mine_map/mine_count are final.
- busy and done are never high together.
- start while busy is ignored, with no queuing.
- start while done = 1 is a new request: done drops and busy rises on the next edge.
- Reset during GEN aborts on that edge; all outputs return to reset values.
- Reset and start asserted on the same edge: Reset wins.

## Structure
- Shared game package holds:
  - Difficulty encoding constants: EASY = 0, MEDIUM = 1, HARD = 2.
  - Board-size masks and default mine counts.
  - The LFSR next-state function.
- One sub-module, `mine_lfsr7`: 7-bit Fibonacci LFSR with load and advance inputs.
- Everything else (FSM, map, counter) lives in `mine_field_gen`.

## Test plan
- Easy, seed_easy = 0, safe_cell = 5, start pulse → candidates 0, 1, 2 are all accepted; done rises 3 cycles after start; mine_map = 64'h7, mine_count = 3.
- Easy, seed_easy = 0, safe_cell = 1 → cell 1 rejected; mine_map = 64'h15 after 4 GEN cycles.
- Medium and hard, 32 random seeds each, random safe_cell → mine_count = 6 and 12 respectively; popcount(mine_map) equals mine_count; safe bit clear; medium bits 63:32 = 0; done within 127 cycles.
- Second start pulse while busy → no effect. Start while done = 1 → new generation; done drops the next cycle.
- Reset asserted mid-GEN, with start asserted on the same edge → all outputs return to reset values and no generation starts.
- Difficulty = 3 → behaves as hard: 12 mines within 0-63.
